// File: rtl/store_stream_guard.sv
// store_stream_guard: follows up to NR_STREAMS runs of address-contiguous stores, retires
// finished runs into a circular range buffer, and requests a crash on load-hit followed by jump.
module store_stream_guard #(
  parameter int unsigned NR_STREAMS  = 4,
  parameter int unsigned RANGE_DEPTH = 8,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT     = 10,
  parameter int unsigned SP_REG      = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           valid_i,
  input  logic [1:0]                     kind_i,
  input  logic [1:0]                     size_i,
  input  logic [4:0]                     rs1_i,
  input  logic [ADDR_W-1:0]              addr_i,
  input  logic [$clog2(RANGE_DEPTH)-1:0] rd_idx_i,
  output logic [ADDR_W-1:0]              rd_first_o,
  output logic [ADDR_W-1:0]              rd_last_o,
  output logic                           rd_valid_o,
  output logic [$clog2(RANGE_DEPTH):0]   count_o,
  output logic [15:0]                    dropped_o,
  output logic                           load_hit_o,
  output logic                           crash_o
);

  localparam int unsigned IDX_W = $clog2(RANGE_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned SID_W = (NR_STREAMS > 1) ? $clog2(NR_STREAMS) : 1;
  localparam int unsigned AW1   = ADDR_W + 1;

  localparam logic [1:0] KIND_STORE = 2'd1;
  localparam logic [1:0] KIND_LOAD  = 2'd2;
  localparam logic [1:0] KIND_JUMP  = 2'd3;

  // stream trackers
  logic [NR_STREAMS-1:0] r_act;
  logic [ADDR_W-1:0]     r_first [NR_STREAMS];
  logic [ADDR_W-1:0]     r_end   [NR_STREAMS];
  logic [TMR_W-1:0]      r_timer [NR_STREAMS];

  // range buffer
  logic [ADDR_W-1:0]     r_buf_first [RANGE_DEPTH];
  logic [ADDR_W-1:0]     r_buf_last  [RANGE_DEPTH];
  logic [IDX_W-1:0]      r_head;
  logic [IDX_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [15:0]           r_dropped;

  logic                  r_load_hit;
  logic                  r_crash;

  logic                  w_store;
  logic [ADDR_W-1:0]     w_len_m1;
  logic [ADDR_W-1:0]     w_new_end;
  logic [NR_STREAMS-1:0] w_match;
  logic                  w_any_match;
  logic                  w_any_free;
  logic [SID_W-1:0]      w_match_idx;
  logic [SID_W-1:0]      w_free_idx;
  logic [SID_W-1:0]      w_evict_idx;
  logic [TMR_W-1:0]      w_min_timer;
  logic                  w_alloc;
  logic                  w_evict;
  logic [SID_W-1:0]      w_tgt_idx;
  logic [NR_STREAMS-1:0] w_touch;
  logic                  w_any_exp;
  logic [SID_W-1:0]      w_exp_idx;
  logic                  w_exp_push;
  logic                  w_push;
  logic [SID_W-1:0]      w_push_sel;
  logic [ADDR_W-1:0]     w_push_first;
  logic [ADDR_W-1:0]     w_push_last;
  logic                  w_load_hit;
  logic [IDX_W-1:0]      w_rel;
  logic [IDX_W-1:0]      w_rd_slot;
  logic                  w_rd_valid;

  // store decode and the new inclusive last byte
  always_comb begin
    w_store = valid_i && (kind_i == KIND_STORE) && (rs1_i != 5'(SP_REG));
    case (size_i)
      2'd0:    w_len_m1 = ADDR_W'(0);
      2'd1:    w_len_m1 = ADDR_W'(1);
      default: w_len_m1 = ADDR_W'(3);
    endcase
    w_new_end = addr_i + w_len_m1;
  end

  // contiguity test done one bit wider so a run ending at the top byte never wraps to zero
  always_comb begin
    w_match = '0;
    for (int i = 0; i < int'(NR_STREAMS); i++) begin
      w_match[i] = r_act[i] && (({1'b0, r_end[i]} + AW1'(1)) == {1'b0, addr_i});
    end
  end

  always_comb begin
    w_any_match = 1'b0;
    w_match_idx = '0;
    w_any_free  = 1'b0;
    w_free_idx  = '0;
    w_evict_idx = '0;
    w_min_timer = r_timer[0];
    for (int i = 0; i < int'(NR_STREAMS); i++) begin
      if (!w_any_match && w_match[i]) begin
        w_any_match = 1'b1;
        w_match_idx = SID_W'(i);
      end
      if (!w_any_free && !r_act[i]) begin
        w_any_free = 1'b1;
        w_free_idx = SID_W'(i);
      end
      if (r_timer[i] < w_min_timer) begin
        w_min_timer = r_timer[i];
        w_evict_idx = SID_W'(i);
      end
    end
  end

  // target selection and the single push slot; an eviction outranks an expiry
  always_comb begin
    w_alloc   = w_store && !w_any_match;
    w_evict   = w_alloc && !w_any_free;
    w_tgt_idx = w_any_match ? w_match_idx : (w_any_free ? w_free_idx : w_evict_idx);
    w_touch   = '0;
    w_any_exp = 1'b0;
    w_exp_idx = '0;
    for (int i = 0; i < int'(NR_STREAMS); i++) begin
      w_touch[i] = w_store && (w_tgt_idx == SID_W'(i));
    end
    for (int i = 0; i < int'(NR_STREAMS); i++) begin
      if (!w_any_exp && r_act[i] && (r_timer[i] == '0) && !w_touch[i]) begin
        w_any_exp = 1'b1;
        w_exp_idx = SID_W'(i);
      end
    end
    w_exp_push   = w_any_exp && !w_evict;
    w_push       = w_evict || w_exp_push;
    w_push_sel   = w_evict ? w_evict_idx : w_exp_idx;
    w_push_first = r_first[w_push_sel];
    w_push_last  = r_end[w_push_sel];
  end

  // load hit against pre-push buffer contents and live streams
  always_comb begin
    w_load_hit = 1'b0;
    w_rel      = '0;
    for (int k = 0; k < int'(RANGE_DEPTH); k++) begin
      w_rel = IDX_W'(k) - r_head;
      if ((CNT_W'(w_rel) < r_count) &&
          (addr_i >= r_buf_first[k]) && (addr_i <= r_buf_last[k])) begin
        w_load_hit = 1'b1;
      end
    end
    for (int i = 0; i < int'(NR_STREAMS); i++) begin
      if (r_act[i] && (addr_i >= r_first[i]) && (addr_i <= r_end[i])) begin
        w_load_hit = 1'b1;
      end
    end
  end

  // read port, indexed from the oldest entry
  always_comb begin
    w_rd_slot  = r_head + rd_idx_i;
    w_rd_valid = CNT_W'(rd_idx_i) < r_count;
    rd_valid_o = w_rd_valid;
    rd_first_o = w_rd_valid ? r_buf_first[w_rd_slot] : '0;
    rd_last_o  = w_rd_valid ? r_buf_last[w_rd_slot]  : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_act      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_load_hit <= 1'b0;
      r_crash    <= 1'b0;
      for (int i = 0; i < int'(NR_STREAMS); i++) begin
        r_first[i] <= '0;
        r_end[i]   <= '0;
        r_timer[i] <= '0;
      end
      for (int k = 0; k < int'(RANGE_DEPTH); k++) begin
        r_buf_first[k] <= '0;
        r_buf_last[k]  <= '0;
      end
      if (rst_i) begin
        r_dropped <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NR_STREAMS); i++) begin
        if (w_touch[i]) begin
          r_act[i]   <= 1'b1;
          r_end[i]   <= w_new_end;
          r_timer[i] <= TMR_W'(TIMEOUT);
          if (!w_any_match) begin
            r_first[i] <= addr_i;
          end
        end else if (w_exp_push && (w_exp_idx == SID_W'(i))) begin
          r_act[i] <= 1'b0;
        end else if (r_act[i] && (r_timer[i] != '0)) begin
          r_timer[i] <= r_timer[i] - TMR_W'(1);
        end
      end

      // a full buffer overwrites its oldest entry
      if (w_push) begin
        r_buf_first[r_tail] <= w_push_first;
        r_buf_last[r_tail]  <= w_push_last;
        r_tail              <= r_tail + IDX_W'(1);
        if (r_count == CNT_W'(RANGE_DEPTH)) begin
          r_head <= r_head + IDX_W'(1);
          if (r_dropped != 16'hFFFF) begin
            r_dropped <= r_dropped + 16'd1;
          end
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      r_crash <= 1'b0;
      if (valid_i && (kind_i == KIND_LOAD)) begin
        r_load_hit <= w_load_hit;
      end else if (valid_i && (kind_i == KIND_JUMP)) begin
        r_crash    <= r_load_hit;
        r_load_hit <= 1'b0;
      end
    end
  end

  assign count_o    = r_count;
  assign dropped_o  = r_dropped;
  assign load_hit_o = r_load_hit;
  assign crash_o    = r_crash;

endmodule

// File: tb/tb_store_stream_guard.sv
// Bench for store_stream_guard: directed scenarios plus random instruction mix,
// compared every cycle against a run/age-based reference model.
module tb_store_stream_guard;

  localparam int unsigned NR = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 10;
  localparam int unsigned SP = 2;
  localparam int unsigned IW = $clog2(D);

  logic              clk = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              valid_i;
  logic [1:0]        kind_i;
  logic [1:0]        size_i;
  logic [4:0]        rs1_i;
  logic [AW-1:0]     addr_i;
  logic [IW-1:0]     rd_idx_i;
  logic [AW-1:0]     rd_first_o;
  logic [AW-1:0]     rd_last_o;
  logic              rd_valid_o;
  logic [IW:0]       count_o;
  logic [15:0]       dropped_o;
  logic              load_hit_o;
  logic              crash_o;

  always #5 clk = ~clk;

  store_stream_guard #(
    .NR_STREAMS(NR), .RANGE_DEPTH(D), .ADDR_W(AW), .TIMEOUT(TO), .SP_REG(SP)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .kind_i(kind_i), .size_i(size_i), .rs1_i(rs1_i), .addr_i(addr_i),
    .rd_idx_i(rd_idx_i), .rd_first_o(rd_first_o), .rd_last_o(rd_last_o),
    .rd_valid_o(rd_valid_o), .count_o(count_o), .dropped_o(dropped_o),
    .load_hit_o(load_hit_o), .crash_o(crash_o)
  );

  // reference model: runs remember their last-touch cycle, buffer is a queue
  bit          m_act   [NR];
  logic [31:0] m_first [NR];
  logic [31:0] m_last  [NR];
  int          m_touch [NR];
  logic [31:0] q_first [$];
  logic [31:0] q_last  [$];
  int          m_dropped;
  bit          m_hit;
  bit          m_crash;
  int          cyc;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic mpush(input logic [31:0] f, input logic [31:0] l);
    if (q_first.size() == int'(D)) begin
      void'(q_first.pop_front());
      void'(q_last.pop_front());
      if (m_dropped < 16'hFFFF) m_dropped++;
    end
    q_first.push_back(f);
    q_last.push_back(l);
  endtask

  task automatic model_step(input bit v, input logic [1:0] k, input logic [1:0] sz,
                            input logic [4:0] r, input logic [31:0] a, input bit fl);
    bit          hit;
    bit          evicted;
    bit          done;
    int          tgt;
    int          best_age;
    int          age;
    logic [31:0] nl;
    cyc++;
    if (fl) begin
      for (int i = 0; i < int'(NR); i++) m_act[i] = 1'b0;
      q_first.delete();
      q_last.delete();
      m_hit   = 1'b0;
      m_crash = 1'b0;
      return;
    end
    hit = 1'b0;
    for (int e = 0; e < q_first.size(); e++)
      if (a >= q_first[e] && a <= q_last[e]) hit = 1'b1;
    for (int i = 0; i < int'(NR); i++)
      if (m_act[i] && a >= m_first[i] && a <= m_last[i]) hit = 1'b1;
    m_crash = 1'b0;
    if (v && k == 2'd2) m_hit = hit;
    else if (v && k == 2'd3) begin
      m_crash = m_hit;
      m_hit   = 1'b0;
    end
    tgt     = -1;
    evicted = 1'b0;
    if (v && k == 2'd1 && r != 5'(SP)) begin
      nl = a + 32'(nbytes(sz) - 1);
      for (int i = 0; i < int'(NR); i++)
        if (tgt < 0 && m_act[i] && m_last[i] != 32'hFFFF_FFFF && m_last[i] + 32'd1 == a) tgt = i;
      if (tgt >= 0) begin
        m_last[tgt]  = nl;
        m_touch[tgt] = cyc;
      end else begin
        for (int i = 0; i < int'(NR); i++)
          if (tgt < 0 && !m_act[i]) tgt = i;
        if (tgt < 0) begin
          best_age = -1;
          for (int i = 0; i < int'(NR); i++) begin
            age = cyc - m_touch[i];
            if (age > int'(TO) + 1) age = int'(TO) + 1;
            if (age > best_age) begin
              best_age = age;
              tgt      = i;
            end
          end
          mpush(m_first[tgt], m_last[tgt]);
          evicted = 1'b1;
        end
        m_act[tgt]   = 1'b1;
        m_first[tgt] = a;
        m_last[tgt]  = nl;
        m_touch[tgt] = cyc;
      end
    end
    if (!evicted) begin
      done = 1'b0;
      for (int i = 0; i < int'(NR); i++) begin
        if (!done && m_act[i] && i != tgt && cyc - m_touch[i] > int'(TO)) begin
          mpush(m_first[i], m_last[i]);
          m_act[i] = 1'b0;
          done     = 1'b1;
        end
      end
    end
  endtask

  task automatic sync();
    int ri;
    @(negedge clk);
    ri = int'(rd_idx_i);
    check("count", 32'(count_o), 32'(q_first.size()));
    check("dropped", 32'(dropped_o), 32'(m_dropped));
    check("load_hit", 32'(load_hit_o), 32'(m_hit));
    check("crash", 32'(crash_o), 32'(m_crash));
    check("rd_valid", 32'(rd_valid_o), 32'(ri < q_first.size()));
    if (ri < q_first.size()) begin
      check("rd_first", rd_first_o, q_first[ri]);
      check("rd_last", rd_last_o, q_last[ri]);
    end else begin
      check("rd_first_empty", rd_first_o, 32'h0);
      check("rd_last_empty", rd_last_o, 32'h0);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] k, input logic [1:0] sz,
                       input logic [4:0] r, input logic [31:0] a, input bit fl);
    valid_i  = v;
    kind_i   = k;
    size_i   = sz;
    rs1_i    = r;
    addr_i   = a;
    flush_i  = fl;
    rd_idx_i = IW'($urandom_range(D - 1));
    model_step(v, k, sz, r, a, fl);
  endtask

  task automatic step(input bit v, input logic [1:0] k, input logic [1:0] sz,
                      input logic [4:0] r, input logic [31:0] a, input bit fl);
    sync();
    drive(v, k, sz, r, a, fl);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b0);
  endtask

  // call only right after sync(): read one entry at a chosen index
  task automatic peek(input string tag, input int idx, input logic [31:0] f, input logic [31:0] l);
    rd_idx_i = IW'(idx);
    #1;
    check({tag, "_valid"}, 32'(rd_valid_o), 32'h1);
    check({tag, "_first"}, rd_first_o, f);
    check({tag, "_last"}, rd_last_o, l);
  endtask

  initial begin
    logic [31:0] next_contig;
    logic [31:0] a;
    logic [1:0]  k;
    logic [1:0]  sz;
    logic [4:0]  rs;
    bit          v;
    bit          fl;
    int          roll;

    n_pass = 0;
    n_total = 0;
    cyc = 0;
    m_dropped = 0;
    m_hit = 1'b0;
    m_crash = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      m_act[i] = 1'b0;
      m_first[i] = '0;
      m_last[i] = '0;
      m_touch[i] = 0;
    end
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; kind_i = '0; size_i = '0;
    rs1_i = '0; addr_i = '0; rd_idx_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_dropped", 32'(dropped_o), 32'h0);
    check("rst_load_hit", 32'(load_hit_o), 32'h0);
    check("rst_crash", 32'(crash_o), 32'h0);
    check("rst_rd_valid", 32'(rd_valid_o), 32'h0);
    check("rst_rd_first", rd_first_o, 32'h0);
    check("rst_rd_last", rd_last_o, 32'h0);
    rst_i = 1'b0;

    // buffer overflow: D+2 isolated runs
    for (int j = 0; j < int'(D) + 2; j++) begin
      step(1'b1, 2'd1, 2'd2, 5'd1, 32'h5000 + 32'(j) * 32'h100, 1'b0);
      idle(int'(TO) + 2);
    end
    sync();
    check("ovf_count", 32'(count_o), 32'(D));
    check("ovf_dropped", 32'(dropped_o), 32'd2);
    peek("ovf_oldest", 0, 32'h5200, 32'h5203);
    drive(1'b0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b1);

    // five contiguous words, retire latency, then load/jump crash
    for (int j = 0; j < 5; j++) step(1'b1, 2'd1, 2'd2, 5'd1, 32'h1000 + 32'(j) * 4, 1'b0);
    idle(int'(TO));
    sync();
    check("retire_not_yet", 32'(count_o), 32'h0);
    drive(1'b0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b0);
    sync();
    check("retire_count", 32'(count_o), 32'h1);
    peek("retire_entry", 0, 32'h1000, 32'h1013);
    drive(1'b1, 2'd2, 2'd2, 5'd1, 32'h100C, 1'b0);
    sync();
    check("lw_hit", 32'(load_hit_o), 32'h1);
    drive(1'b1, 2'd3, 2'd0, 5'd1, 32'h0, 1'b0);
    sync();
    check("jalr_crash", 32'(crash_o), 32'h1);
    check("jalr_clears_hit", 32'(load_hit_o), 32'h0);
    drive(1'b1, 2'd2, 2'd2, 5'd1, 32'h1014, 1'b0);
    sync();
    check("lw_miss", 32'(load_hit_o), 32'h0);
    drive(1'b1, 2'd3, 2'd0, 5'd1, 32'h0, 1'b0);
    sync();
    check("jal_no_crash", 32'(crash_o), 32'h0);
    drive(1'b0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b1);

    // byte then half chain, second run allocated
    step(1'b1, 2'd1, 2'd0, 5'd1, 32'h2000, 1'b0);
    step(1'b1, 2'd1, 2'd1, 5'd1, 32'h2001, 1'b0);
    step(1'b1, 2'd1, 2'd2, 5'd1, 32'h2010, 1'b0);
    step(1'b1, 2'd2, 2'd0, 5'd1, 32'h2002, 1'b0);
    sync();
    check("chain_end_hit", 32'(load_hit_o), 32'h1);
    drive(1'b1, 2'd2, 2'd0, 5'd1, 32'h2003, 1'b0);
    sync();
    check("chain_past_end", 32'(load_hit_o), 32'h0);
    drive(1'b0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b0);
    idle(int'(TO) + 2);
    sync();
    check("chain_count", 32'(count_o), 32'h2);
    peek("chain_e0", 0, 32'h2000, 32'h2002);
    peek("chain_e1", 1, 32'h2010, 32'h2013);
    drive(1'b0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b1);

    // NR+1 scattered words force an eviction of the oldest run
    for (int j = 0; j <= int'(NR); j++) step(1'b1, 2'd1, 2'd2, 5'd1, 32'h3000 + 32'(j) * 32'h100, 1'b0);
    sync();
    check("evict_count", 32'(count_o), 32'h1);
    peek("evict_entry", 0, 32'h3000, 32'h3003);
    drive(1'b0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b1);

    // stack store ignored; no wrap-around chaining
    step(1'b1, 2'd1, 2'd2, 5'(SP), 32'h6000, 1'b0);
    step(1'b1, 2'd2, 2'd2, 5'd1, 32'h6000, 1'b0);
    sync();
    check("sp_ignored", 32'(load_hit_o), 32'h0);
    drive(1'b1, 2'd1, 2'd2, 5'd1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 2'd1, 2'd2, 5'd1, 32'h0000_0000, 1'b0);
    idle(int'(TO) + 2);
    sync();
    check("wrap_count", 32'(count_o), 32'h2);
    check("flush_keeps_dropped", 32'(dropped_o), 32'd2);
    peek("wrap_e0", 0, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    peek("wrap_e1", 1, 32'h0000_0000, 32'h0000_0003);
    drive(1'b0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b0);

    // random instruction mix
    next_contig = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39) == 0) begin
        idle(int'($urandom_range(20, 12)));
      end else begin
        roll = int'($urandom_range(99));
        fl   = ($urandom_range(299) == 0);
        v    = ($urandom_range(9) != 0);
        sz   = 2'($urandom_range(3));
        rs   = 5'($urandom_range(3));
        if (roll < 45) k = 2'd1;
        else if (roll < 65) k = 2'd2;
        else if (roll < 75) k = 2'd3;
        else k = 2'd0;
        if (k == 2'd1 && $urandom_range(1) == 1) a = next_contig;
        else if ($urandom_range(49) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(15));
        else a = 32'h1000 + 32'($urandom_range(255));
        if (v && k == 2'd1) next_contig = a + 32'(nbytes(sz));
        step(v, k, sz, rs, a, fl);
      end
    end
    sync();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
